tri_bus_rx: RTL
===============

Name: tri_bus_rx

Overview:
- Receive endpoint for the team's shared tristate data bus. The driving module places a word on the bus with a strobe; this block captures each strobed word into a small FIFO for the local consumer.
- Flow control back to the driver uses a shared wired line, bus_hold_n. This block drives that line low when it cannot accept a word and releases it to high-Z otherwise. An external pull-up resolves the released line to 1.
- It also checks an even-parity bit on each word and reports sticky error and overflow status.

Parameters:
- WIDTH, 8, data bits per bus word.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk input 1: single clock; all state updates on its rising edge.
- rst_n input 1: asynchronous, active-low reset.
- bus_data input WIDTH: resolved value of the shared tristate data bus.
- bus_par input 1: even-parity bit sent with bus_data.
- bus_strb input 1: the driver asserts this for exactly one cycle per word.
- bus_hold_n output 1: tristate. Drives 0 when the FIFO is full; 'bz otherwise.
- rd_data output WIDTH: head-of-FIFO word.
- rd_perr output 1: parity-error tag of the head word.
- rd_valid output 1: FIFO is not empty.
- rd_ready input 1: consumer pop request.
- count output $clog2(DEPTH)+1: current FIFO occupancy.
- ovf output 1: sticky overflow flag.
- perr output 1: sticky parity-error flag.
- clr_err input 1: synchronous clear of ovf and perr.

Behaviour:
- Reset (rst_n=0, asynchronous)
  - count=0, rd_valid=0, ovf=0, perr=0.
  - Read and write pointers = 0.
  - bus_hold_n = 'bz (released). The released state holds throughout reset.
  - rd_data / rd_perr contents are don't-care while rd_valid=0.
- Push: on a rising edge with bus_strb=1 and count<DEPTH:
  - store {parity_fail, bus_data} at the write pointer;
  - advance the write pointer modulo DEPTH, wrapping naturally.
- Parity check: parity_fail = ^{bus_data, bus_par}, i.e. 1 when the total number of ones is odd. Any accepted word with parity_fail=1 sets perr the next cycle. The word is still stored, with its tag.
- Overflow: bus_strb=1 while count==DEPTH
  - the word is dropped and ovf is set;
  - this applies even if rd_ready pops on the same edge, so no pass-through on a full FIFO;
  - the parity of a dropped word is not checked.
- Pop: on a rising edge with rd_valid=1 and rd_ready=1, advance the read pointer modulo DEPTH. rd_ready while empty is ignored.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
  - When count==0, a push is accepted and the pop is ignored, giving count=1.
- Read latency:
  - rd_data / rd_perr come combinationally from the registered storage at the read pointer (first-word fall-through).
  - A word pushed at edge N is visible with rd_valid=1 after edge N, i.e. one cycle of latency.
- Hold line:
  - bus_hold_n is driven 0 when the registered count==DEPTH; otherwise it is 'bz.
  - It is derived from registered state only; there is no combinational path from bus inputs.
  - The driver is required to sample bus_hold_n in the same cycle it would assert bus_strb.
- Sticky flags: ovf and perr stay set until clr_err=1 at an edge.
  - On an edge where clr_err and a new error event coincide, the flag stays set (the set wins).
- count:
  - increments on push only;
  - decrements on pop only;
  - holds on both or neither;
  - never exceeds DEPTH and never goes below 0.
- Storage: not reset; only the pointers and count are reset.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then release with no strobes → count=0, rd_valid=0, ovf=0, perr=0, bus_hold_n resolves to 1 via pull-up (z from this block).
- Single word: bus_data=8'hA5 with bus_par=0 (4 ones, even) strobed once → next cycle rd_valid=1, rd_data=8'hA5, rd_perr=0, count=1. Pulse rd_ready → rd_valid=0, count=0.
- Fill, overflow and drain (DEPTH=4):
  - push 8'h01..8'h04 → count=4, bus_hold_n driven 0;
  - strobe 8'h05 → ovf=1, count stays 4;
  - pop 4 times → data 01,02,03,04 in order, bus_hold_n back to z after the first pop.
- Wrap-around: 10 words streamed with a pop on every cycle after the first push → all 10 delivered in order, count stays at 1, pointers wrap twice, ovf=0.
- Parity error: bus_data=8'h03 with bus_par=1 (3 ones, odd) → word stored with rd_perr=1, perr=1. clr_err pulse → perr=0; the tagged word remains in the FIFO.
- Reset mid-operation: with count=3, pull rst_n low asynchronously between clock edges → count=0, rd_valid=0, ovf=0, bus_hold_n=z immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tri_bus_rx_if.sv
// Bus-side and consumer-side signal bundle for tri_bus_rx.
//
// Purpose:
//   Groups the strobed word arriving from the shared tristate data bus and
//   the first-word-fall-through read handshake toward the local consumer.
//
// Signals:
//   bus_data  - resolved value of the shared data bus
//   bus_par   - even-parity bit travelling with bus_data
//   bus_strb  - one-cycle strobe per word from the driving module
//   rd_data   - head-of-FIFO word
//   rd_perr   - parity-error tag of the head word
//   rd_valid  - FIFO not empty
//   rd_ready  - consumer pop request
//
// Modports:
//   slave  - the receiver (tri_bus_rx): consumes bus signals, sources read port
//   master - the environment: drives bus signals and rd_ready, observes read port
//
// The wired bus_hold_n line is deliberately not part of this bundle. It is a
// resolved net shared with other agents and needs an external pull-up, so it
// stays a plain tristate port on the receiver.
interface tri_bus_rx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] bus_data;
  logic             bus_par;
  logic             bus_strb;
  logic [WIDTH-1:0] rd_data;
  logic             rd_perr;
  logic             rd_valid;
  logic             rd_ready;

  modport slave (
    input  bus_data,
    input  bus_par,
    input  bus_strb,
    input  rd_ready,
    output rd_data,
    output rd_perr,
    output rd_valid
  );

  modport master (
    output bus_data,
    output bus_par,
    output bus_strb,
    output rd_ready,
    input  rd_data,
    input  rd_perr,
    input  rd_valid
  );
endinterface

// File: rtl/tri_bus_rx.sv
// Receive endpoint for the shared tristate data bus.
//
// Purpose:
//   Captures every strobed bus word, together with a parity-fail tag, into a
//   small first-word-fall-through FIFO for the local consumer. Back-pressure
//   to the driver is a wired line pulled low while the FIFO is full. Sticky
//   overflow and parity-error flags are kept until cleared.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - tri_bus_rx_if.slave: bus word/parity/strobe in, read port out
//   bus_hold_n - tristate hold line: 0 while full, released (z) otherwise
//   count      - current FIFO occupancy (0..DEPTH)
//   ovf        - sticky overflow flag (strobe seen while full)
//   perr       - sticky parity-error flag (accepted word with odd parity)
//   clr_err    - synchronous clear of ovf and perr; a coincident new event wins
//
// Parameters:
//   WIDTH - data bits per bus word
//   DEPTH - FIFO entries, power of two and at least 2
module tri_bus_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tri_bus_rx_if.slave              bus,
  output wire                      bus_hold_n,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     perr,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Each entry carries the parity-fail tag above the data bits.
  logic [WIDTH:0]  mem_q [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            perr_q, perr_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            parity_fail;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign parity_fail = ^{bus.bus_data, bus.bus_par};

  // A strobe on a full FIFO is dropped even if the consumer pops on the same
  // edge, so there is no pass-through path for a word while full.
  assign push = bus.bus_strb & ~full;
  assign pop  = bus.rd_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the increment wrap modulo DEPTH on its own.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Set has priority over clear so an error on the clearing edge is kept.
    // Dropped words are never parity-checked, hence the use of push here.
    ovf_d  = (bus.bus_strb & full) | (ovf_q & ~clr_err);
    perr_d = (push & parity_fail)  | (perr_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is intentionally left unreset; its contents are only observed
  // through rd_valid, which depends solely on the reset count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {parity_fail, bus.bus_data};
    end
  end

  // First-word fall-through: the head entry is read straight from storage.
  assign bus.rd_data  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign bus.rd_perr  = mem_q[rd_ptr_q][WIDTH];
  assign bus.rd_valid = ~empty;

  assign count = count_q;
  assign ovf   = ovf_q;
  assign perr  = perr_q;

  // Hold comes from the registered count only, so reset immediately releases
  // the line and bus inputs never reach it combinationally.
  assign bus_hold_n = full ? 1'b0 : 1'bz;

endmodule
